uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered 8N1 UART transmitter for the tt_um_uart_8bit design. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them LSB-first on a single output line. Baud timing comes from an integer clock divider. It is the transmit-direction counterpart to the existing serial receive path and drives the top-level TX pin, with tx_ready/busy routed to uo_out status bits.

## Interface
- BAUD_RATE, 24'd115200, serial bit rate in bits/s
- CLOCK_FREQ, 28'd50000000, clk frequency in Hz
- FIFO_DEPTH, 4, byte entries; power of two, minimum 2
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- tx_data  input  8  byte to send; sampled when tx_valid && tx_ready
- tx_valid  input  1  producer has a byte
- tx_ready  output  1  FIFO not full; write accepted on rising edge with tx_valid=1
- tx  output  1  serial line; idle high; registered
- busy  output  1  shifter in a non-IDLE state
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently stored

## Operation
- DIV = CLOCK_FREQ / BAUD_RATE, integer truncation. DIV < 2 is an elaboration error.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: tx=1. When the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter and bit index, and go to START.
- START: tx=0 for DIV cycles, then go to DATA.
- DATA: tx = shift_reg[0] for DIV cycles per bit, then shift right. After bit index 7, go to PARITY or STOP.
- STOP: tx=1 for DIV cycles. At its last cycle:
  - if the FIFO is non-empty, pop and go directly to START (no idle gap);
  - otherwise go to IDLE.
- Baud counter: counts 0..DIV-1 and wraps. A bit ends on the cycle the counter equals DIV-1.
- FIFO:
  - tx_ready = (fifo_level != FIFO_DEPTH). There is no write-through when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves the level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Bytes are never dropped or reordered. Writes while tx_ready=0 are ignored.
- Reset values: tx=1, busy=0, tx_ready=1, fifo_level=0, state IDLE, pointers 0, shift_reg 0.
- Reset asserted mid-frame: tx goes high immediately (asynchronously), the FIFO empties, and the partial frame is abandoned. No resume after reset.

## Timing
- Write accepted at edge N with the FIFO empty and the FSM in IDLE:
  - pop at edge N+1;
  - tx falls and busy rises at edge N+1, i.e. one cycle after acceptance.
- Frame length: 10*DIV cycles, or 11*DIV with parity. Consecutive frames are contiguous.
- fifo_level and tx_ready update on the edge following the push/pop.
- busy falls at the edge that enters IDLE, which coincides with the end of the stop bit.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state inserted after DATA;
  - tx = XOR of the 8 data bits (even parity) for DIV cycles.
- UART_TX_PARITY_EN undefined: no PARITY state and no parity logic; the frame is 8N1.

## Structure
- Shared package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - UART_DATA_W = 8;
  - function computing DIV from CLOCK_FREQ/BAUD_RATE.
- The enum is shared with the receive path.
- One natural sub-module: uart_baud_gen.
  - Inputs: clk, rst_n, clear.
  - Output: bit_end pulse.
  - Parameter: DIV.
  - Reusable by the receiver.
- The FIFO stays inline (register array plus pointers).

## Test plan
Bench uses BAUD_RATE 24'd4000000 and CLOCK_FREQ 28'd100000000, giving DIV = 25.
- Reset: hold rst_n=0 for 10 cycles -> tx=1, busy=0, tx_ready=1, fifo_level=0.
- Single byte 0xA5 -> tx falls 1 cycle after acceptance. Sampled mid-bit every 25 cycles, tx reads 0, 1,0,1,0,0,1,0,1, 1. busy is high for exactly 250 cycles.
- Back-to-back: tx_valid held high with bytes 0x01..0x06 from the idle state:
  - 5 bytes accepted, then tx_ready=0;
  - one further byte accepted at each pop;
  - all six frames contiguous (1500 cycles) and in order.
- Full boundary: with the FIFO full and a pop occurring in the same cycle as tx_valid=1, the write is not accepted. tx_ready rises on the next edge and fifo_level=FIFO_DEPTH-1.
- Reset mid-frame: rst_n asserted during the DATA bit 3 of 0x3C with 2 bytes queued -> tx=1 immediately, fifo_level=0. After release, no frame is emitted.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 275 cycles. Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, widths and baud divider helper for the tx and rx paths.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  function automatic int calc_div(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running 0..DIV-1 counter with a bit_end pulse on the last cycle of each bit.
module uart_baud_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);
  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  if (DIV < 2) begin : g_div_check
    $error("uart_baud_gen: DIV must be at least 2");
  end
  logic [CW-1:0] cnt;
  assign bit_end = cnt == CW'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clear || bit_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter with inline FIFO; define UART_TX_PARITY_EN for an even-parity bit (8E1).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter logic [23:0] BAUD_RATE  = 24'd115200,
  parameter logic [27:0] CLOCK_FREQ = 28'd50000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [UART_DATA_W-1:0]        tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DIV = calc_div(int'(CLOCK_FREQ), int'(BAUD_RATE));
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_depth_check
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end
  logic [UART_DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [UART_DATA_W-1:0] shift_reg;
  logic [2:0]             bit_idx;
  tx_state_t              state;
  logic                   bit_end, push, pop, empty;
`ifdef UART_TX_PARITY_EN
  logic                   par;
`endif
  assign empty    = fifo_level == '0;
  assign tx_ready = fifo_level != LW'(FIFO_DEPTH);
  assign push     = tx_valid && tx_ready;
  assign pop      = !empty && (state == IDLE || (state == STOP && bit_end));
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE),
    .bit_end (bit_end)
  );
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= tx_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  // A pop always launches a start bit, whether from IDLE or straight out of STOP.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (pop) begin
      state     <= START;
      tx        <= 1'b0;
      busy      <= 1'b1;
      shift_reg <= mem[rd_ptr];
      bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
      par       <= ^mem[rd_ptr];
`endif
    end else if (bit_end) begin
      case (state)
        START: begin
          state <= DATA;
          tx    <= shift_reg[0];
        end
        DATA: begin
          shift_reg <= shift_reg >> 1;
          bit_idx   <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx    <= par;
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else tx <= shift_reg[1];
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state <= STOP;
          tx    <= 1'b1;
        end
`endif
        STOP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo at DIV = 25; also covers the UART_TX_PARITY_EN build.
module tb_uart_tx_fifo;
  import uart_pkg::*;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 275;
`else
  localparam int FRAME = 250;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [2:0] fifo_level;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(
    .BAUD_RATE  (24'd4000000),
    .CLOCK_FREQ (28'd100000000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    int   n;
    logic acc;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    do begin
      acc = tx_ready;
      @(posedge clk);
      if (!acc) @(negedge clk);
      n++;
    end while (!acc && n < 1000);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_accept: byte %02h not accepted after %0d cycles", b, n);
    end else exp_q.push_back(b);
  endtask

  task automatic recv_frame();
    int         n;
    logic [7:0] d, e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 2000);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL frame_start_timeout: tx=%b after %0d cycles, required 0", tx, n);
      return;
    end
    e = 8'hxx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    repeat (12) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL start_bit: tx=%b required 0", tx);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (25) @(negedge clk);
      d[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (25) @(negedge clk);
    checks++;
    if (tx !== ^e) begin
      errors++;
      $display("FAIL parity_bit: tx=%b required %b for byte %02h", tx, ^e, e);
    end
`endif
    repeat (25) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL stop_bit: tx=%b required 1", tx);
    end
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL frame_data: got %02h required %02h", d, e);
    end
  endtask

  task automatic count_busy(input int expected, input string name);
    int n, w;
    w = 0;
    while (busy !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != expected) begin
      errors++;
      $display("FAIL %s: busy high %0d cycles, required %0d", name, n, expected);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    checks += 4;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    send(8'hA5);
    @(negedge clk);
    tx_valid = 1'b0;
    checks += 2;
    if (tx !== 1'b1) begin errors++; $display("FAIL single_pre_tx: got %b required 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_pre_busy: got %b required 0", busy); end
    fork
      recv_frame();
      begin
        @(negedge clk);
        checks += 2;
        if (tx !== 1'b0) begin errors++; $display("FAIL single_latency_tx: got %b required 0", tx); end
        if (busy !== 1'b1) begin errors++; $display("FAIL single_latency_busy: got %b required 1", busy); end
        count_busy(FRAME, "single_busy_len");
      end
    join
  endtask

  task automatic test_back_to_back();
    fork
      begin
        int n;
        for (int i = 1; i <= 5; i++) send(8'(i));
        @(negedge clk);
        tx_data = 8'h06;
        checks += 2;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b required 0", tx_ready); end
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_full_level: got %0d required 4", fifo_level); end
        n = 0;
        while (fifo_level === 3'd4 && n < 400) begin
          @(negedge clk);
          n++;
        end
        checks += 2;
        if (fifo_level !== 3'd3) begin errors++; $display("FAIL full_pop_level: got %0d required 3", fifo_level); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b required 1", tx_ready); end
        @(posedge clk);
        exp_q.push_back(8'h06);
        @(negedge clk);
        tx_valid = 1'b0;
      end
      repeat (6) recv_frame();
      count_busy(6 * FRAME, "b2b_busy_len");
    join
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_leftover: %0d bytes never sent, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    send(8'h3C);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (111) @(negedge clk);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b required 1", busy); end
    if (fifo_level !== 3'd2) begin errors++; $display("FAIL midrst_pre_level: got %0d required 2", fifo_level); end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b required 1", tx); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL midrst_level: got %0d required 0", fifo_level); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", tx_ready); end
    exp_q.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_no_resume: %0d active cycles, required 0", bad); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    send(8'h07);
    @(negedge clk);
    tx_valid = 1'b0;
    fork
      recv_frame();
      count_busy(275, "parity_frame_len");
    join
    send(8'h03);
    @(negedge clk);
    tx_valid = 1'b0;
    recv_frame();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
